// File: rtl/minterm_sweeper_pkg.sv
// Shared types and helpers for the minterm sweeper.
// Holds the sweep state enum, the truth-table width helper and the Gray-code helper.
// No logic of its own; imported by minterm_sweeper and minterm_lookup.
package minterm_sweeper_pkg;

  typedef enum logic [1:0] {
    SW_IDLE = 2'd0,
    SW_RUN  = 2'd1,
    SW_DONE = 2'd2
  } sw_state_t;

  // Bits in one function's truth table: one per minterm.
  function automatic int mask_w(input int n_vars);
    return 1 << n_vars;
  endfunction

  // Binary-reflected Gray code; callers truncate to their index width.
  function automatic logic [31:0] to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/minterm_lookup.sv
// Purpose: read one function's value at a variable vector from its truth table.
// Latency: combinational, zero cycles. Backpressure: none (pure lookup).
// Ports: tbl = truth table (bit m is the value at minterm m), sel = variable vector, val = result.
module minterm_lookup
  import minterm_sweeper_pkg::*;
#(
  parameter int N_VARS = 4
) (
  input  logic [mask_w(N_VARS)-1:0] tbl,
  input  logic [N_VARS-1:0]         sel,
  output logic                      val
);

  assign val = tbl[sel];

endmodule

// File: rtl/minterm_sweeper.sv
// Purpose: sweep all 2^N_VARS minterms, stream vars + N_FUNCS function values, count true minterms.
// Latency: first beat one cycle after start; 2^N_VARS+2 cycles start-to-done with ready_i held high.
// Backpressure: valid/ready; beat held stable while ready_i=0; abort_i wins over a same-cycle accept.
// Ports: start_i/abort_i control, mask_i truth tables (latched at start), ready_i consumer handshake;
//        valid_o/m_o/vars_o/f_o beat, count_o per-function ones count, busy_o in RUN, done_o pulse.
// Build option: define SWEEP_GRAY_EN to present vars_o in Gray order (m_o stays binary).
module minterm_sweeper
  import minterm_sweeper_pkg::*;
#(
  parameter int N_VARS  = 4,
  parameter int N_FUNCS = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [N_FUNCS*(1<<N_VARS)-1:0]  mask_i,
  input  logic                            ready_i,
  output logic                            valid_o,
  output logic [N_VARS-1:0]               m_o,
  output logic [N_VARS-1:0]               vars_o,
  output logic [N_FUNCS-1:0]              f_o,
  output logic [N_FUNCS*(N_VARS+1)-1:0]   count_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int                MW   = mask_w(N_VARS);
  localparam int                CW   = N_VARS + 1;
  localparam logic [N_VARS-1:0] LAST = N_VARS'(MW - 1);

  sw_state_t                 state_q, state_d;
  logic [N_FUNCS*MW-1:0]     mask_q;
  logic [N_VARS-1:0]         idx_q;
  logic [N_FUNCS*CW-1:0]     cnt_q;
  logic [N_VARS-1:0]         vars;
  logic [N_FUNCS-1:0]        fval;
  logic                      start_ok;
  logic                      accept;

`ifdef SWEEP_GRAY_EN
  assign vars = N_VARS'(to_gray(32'(idx_q)));
`else
  assign vars = idx_q;
`endif

  for (genvar f = 0; f < N_FUNCS; f++) begin : g_lookup
    minterm_lookup #(.N_VARS(N_VARS)) u_lookup (
      .tbl (mask_q[f*MW +: MW]),
      .sel (vars),
      .val (fval[f])
    );
  end

  // accept here means a counted accept: abort suppresses it.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    accept   = 1'b0;
    case (state_q)
      SW_IDLE: begin
        if (start_i) begin
          start_ok = 1'b1;
          state_d  = SW_RUN;
        end
      end
      SW_RUN: begin
        if (abort_i) begin
          state_d = SW_IDLE;
        end else if (ready_i) begin
          accept = 1'b1;
          if (idx_q == LAST) state_d = SW_DONE;
        end
      end
      SW_DONE: state_d = SW_IDLE;
      default: state_d = SW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SW_IDLE;
    else        state_q <= state_d;
  end

  // Index stops at LAST on the final accept; RUN exits before it could wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (start_ok) begin
      mask_q <= mask_i;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      for (int f = 0; f < N_FUNCS; f++) begin
        cnt_q[f*CW +: CW] <= cnt_q[f*CW +: CW] + CW'(fval[f]);
      end
      if (idx_q != LAST) idx_q <= idx_q + 1'b1;
    end
  end

  assign valid_o = (state_q == SW_RUN);
  assign busy_o  = (state_q == SW_RUN);
  assign done_o  = (state_q == SW_DONE);
  assign m_o     = idx_q;
  assign vars_o  = vars;
  assign f_o     = fval;
  assign count_o = cnt_q;

endmodule

// File: tb/tb_minterm_sweeper.sv
// Bench for minterm_sweeper: directed scenarios plus randomized sweeps against a beat-level model.
module tb_minterm_sweeper;
  localparam int NV = 4;
  localparam int NF = 2;
  localparam int MW = 16;
  localparam int CW = NV + 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic               abort_i = 1'b0;
  logic               ready_i = 1'b0;
  logic [NF*MW-1:0]   mask_i = '0;
  logic               valid_o;
  logic [NV-1:0]      m_o;
  logic [NV-1:0]      vars_o;
  logic [NF-1:0]      f_o;
  logic [NF*CW-1:0]   count_o;
  logic               busy_o;
  logic               done_o;

  int n_chk = 0;
  int n_bad = 0;

  minterm_sweeper #(.N_VARS(NV), .N_FUNCS(NF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .abort_i (abort_i),
    .mask_i  (mask_i),
    .ready_i (ready_i),
    .valid_o (valid_o),
    .m_o     (m_o),
    .vars_o  (vars_o),
    .f_o     (f_o),
    .count_o (count_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: beat k visits variable vector k (binary) or its Gray code.
  function automatic logic [NV-1:0] exp_vars(input int k);
`ifdef SWEEP_GRAY_EN
    return NV'(k ^ (k >> 1));
`else
    return NV'(k);
`endif
  endfunction

  function automatic logic [NF-1:0] exp_f(input logic [NF*MW-1:0] msk, input int k);
    logic [NF-1:0] r;
    int v;
    v = int'(exp_vars(k));
    for (int f = 0; f < NF; f++) r[f] = msk[f*MW + v];
    return r;
  endfunction

  function automatic logic [NF*CW-1:0] pack_cnt(input int c[NF]);
    logic [NF*CW-1:0] r;
    r = '0;
    for (int f = 0; f < NF; f++) r[f*CW +: CW] = CW'(c[f]);
    return r;
  endfunction

  // rmode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready.
  // abort_m / restart_m: beat index at which to abort / re-issue start (-1 = never).
  task automatic run_sweep(input logic [NF*MW-1:0] msk, input int rmode,
                           input int abort_m, input int restart_m);
    int k, cyc, pat;
    int cnt[NF];
    logic rdy, ab, fin;
    logic [NF-1:0] ef;
    for (int f = 0; f < NF; f++) cnt[f] = 0;
    @(negedge clk);
    mask_i  = msk;
    start_i = 1'b1;
    ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    mask_i  = ~msk;
    k = 0; cyc = 0; pat = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      ef = exp_f(msk, k);
      chk("valid", valid_o, 1);
      chk("busy", busy_o, 1);
      chk("done_early", done_o, 0);
      chk("m", m_o, k);
      chk("vars", vars_o, exp_vars(k));
      chk("f", f_o, ef);
      chk("cnt_run", count_o, pack_cnt(cnt));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (pat % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pat++;
      ab      = (k == abort_m) && rdy;
      start_i = (k == restart_m);
      if (k == restart_m) mask_i = ~msk;
      ready_i = rdy;
      abort_i = ab;
      @(negedge clk);
      start_i = 1'b0;
      abort_i = 1'b0;
      ready_i = 1'b0;
      if (ab) begin
        fin = 1'b1;
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_cnt", count_o, pack_cnt(cnt));
      end else if (rdy) begin
        for (int f = 0; f < NF; f++) cnt[f] += int'(ef[f]);
        if (k == MW - 1) begin
          fin = 1'b1;
          chk("done_pulse", done_o, 1);
          chk("done_valid", valid_o, 0);
          chk("done_cnt", count_o, pack_cnt(cnt));
        end else begin
          k++;
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    chk("done_once", done_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", valid_o, 0);
    chk("cnt_hold", count_o, pack_cnt(cnt));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_m"}, m_o, 0);
    chk({tag, "_vars"}, vars_o, 0);
    chk({tag, "_f"}, f_o, 0);
    chk({tag, "_cnt"}, count_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  initial begin
    int c;
    logic [NF*MW-1:0] rm;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Baseline: ones exactly at m=8..14 in both functions.
    run_sweep({16'h7F00, 16'h7F00}, 0, -1, -1);
    chk("base_cnt", count_o, {5'd7, 5'd7});

    // Backpressure pattern 1,0,0.
    run_sweep({16'h7F00, 16'h7F00}, 1, -1, -1);
    chk("bp_cnt", count_o, {5'd7, 5'd7});

    // Abort together with the accept of m=5.
    run_sweep({16'h0000, 16'hFFFF}, 0, 5, -1);
    chk("abort_final", count_o, {5'd0, 5'd5});
    @(negedge clk);
    chk("abort_no_done", done_o, 0);

    // Second start with a different mask at m=3 is ignored.
    run_sweep({16'h7F00, 16'h7F00}, 0, -1, 3);
    chk("restart_cnt", count_o, {5'd7, 5'd7});

    // Reset mid-sweep at m=9.
    @(negedge clk);
    mask_i  = {16'hAAAA, 16'h5555};
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    ready_i = 1'b1;
    c = 0;
    while (m_o != NV'(9) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("reach_m9", m_o, 9);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single minterm 0 on f0: one true value whatever the visit order.
    run_sweep({16'h0000, 16'h0001}, 2, -1, -1);
    chk("single_cnt", count_o, {5'd0, 5'd1});

    // Randomized sweeps.
    for (int i = 0; i < 8; i++) begin
      rm = {16'($urandom), 16'($urandom)};
      run_sweep(rm, int'($urandom_range(0, 2)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MW - 1)) : -1,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MW - 1)) : -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/minterm_sweeper.md
Name: minterm_sweeper

Overview:
- Sequential truth-table engine for N_FUNCS boolean functions of N_VARS variables.
- Each function is supplied as a minterm mask. On start, the block sweeps every minterm index m = 0 .. 2^N_VARS-1.
- For each index it emits the variable vector and every function value as a valid/ready stream, and accumulates a per-function count of true minterms.
- It sits between the exercise-function stimulus logic and result capture/display, replacing hand-written per-function sweep loops.

Parameters:
- N_VARS, 4: number of input variables; vars_o[N_VARS-1] is the most significant variable (x), vars_o[0] the least significant (z).
- N_FUNCS, 2: number of functions evaluated in parallel.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  begin sweep; sampled only in IDLE.
- abort_i  in  1  cancel sweep; sampled in RUN.
- mask_i  in  N_FUNCS*2^N_VARS  truth tables; function f uses bits [f*2^N_VARS +: 2^N_VARS], and bit m is the value at minterm m.
- ready_i  in  1  consumer accepts the current output.
- valid_o  out  1  output beat valid.
- m_o  out  N_VARS  sweep index of the current beat.
- vars_o  out  N_VARS  variable assignment of the current beat.
- f_o  out  N_FUNCS  function values at vars_o.
- count_o  out  N_FUNCS*(N_VARS+1)  per-function ones count.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched mask 0, counts 0.
- Reset mid-sweep aborts immediately; there is no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start_i=1: latch mask_i, clear counts and index, go to RUN.
  - The first beat (m_o=0) shows valid_o=1 on the cycle after start is sampled.
  - mask_i is ignored outside this latch point.
- RUN:
  - valid_o=1.
  - Outputs are registered and held stable while ready_i=0.
  - An accept is valid_o & ready_i. On an accept:
    - each count_o field adds its f_o bit;
    - if m_o < 2^N_VARS-1, the next cycle presents m_o+1;
    - if m_o = 2^N_VARS-1, go to DONE and drop valid_o.
  - Back-to-back accepts yield one beat per cycle; total sweep latency is 2^N_VARS+2 cycles with ready_i held high.
- DONE: done_o=1 for exactly one cycle, then IDLE. count_o holds its final value until the next start.
- abort_i in RUN:
  - next state is IDLE, valid_o=0, no done_o;
  - counts freeze at their partial value;
  - abort has priority over a simultaneous accept, so the beat is not counted.
- start_i in RUN or DONE is ignored; there is no queuing.
- Counter widths:
  - index is N_VARS bits; wrap past 2^N_VARS-1 is unreachable, because RUN exits first;
  - counts are N_VARS+1 bits, so 2^N_VARS fits without overflow.
- f_o[f] equals latched_mask[f*2^N_VARS + vars_o] (table lookup, no arithmetic carry).

Optional Feature:
- Macro: SWEEP_GRAY_EN.
- When defined:
  - vars_o = m_o ^ (m_o >> 1), i.e. Gray-order sweep with one variable changing per beat;
  - f_o is looked up at the Gray vector;
  - m_o still counts 0,1,2,...
- When undefined: vars_o = m_o (binary order).
- Counts are identical in both builds, since every minterm is visited once.

Decomposition:
- Shared package holds:
  - the state enum (SW_IDLE, SW_RUN, SW_DONE);
  - a helper function for mask width 2^N_VARS;
  - a helper function for the Gray conversion.
- One natural sub-module: minterm_lookup. It is combinational: latched mask slice plus vars vector in, one function bit out, instantiated N_FUNCS times.

Test Plan:
- Baseline sweep:
  - Stimulus: N_VARS=4, N_FUNCS=2, mask_i = {16'h7F00, 16'h7F00}, ready_i=1, start pulse.
  - Response: 16 beats m=0..15; f_o = 2'b11 exactly for m=8..14; done_o pulses once; count_o = {5'd7, 5'd7}.
- Backpressure:
  - Stimulus: same masks, ready_i toggling 1,0,0,1,...
  - Response: beats never skipped or duplicated; outputs stable while ready_i=0; final counts 7/7.
- Abort:
  - Stimulus: abort_i asserted in the same cycle as the accept of m=5, masks 16'hFFFF/16'h0000.
  - Response: valid_o=0 next cycle; no done_o; count_o = {5'd0, 5'd5}.
- Reset mid-sweep:
  - Stimulus: rst_n low during m=9.
  - Response: all outputs 0 asynchronously; IDLE; a new start restarts at m=0.
- Start ignored while busy:
  - Stimulus: second start_i with a different mask at m=3.
  - Response: sweep continues with the original mask; exactly one done_o.
- Gray build:
  - Stimulus: SWEEP_GRAY_EN defined, mask 16'h0001 on f0.
  - Response: vars_o sequence 0,1,3,2,6,...; f_o[0]=1 only at m_o=0; count=1.
